ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Instruction fetch front end that sits directly upstream of the instruction cache. It owns the fetch PC and issues one-instruction requests on the cache's `mem_*` port. It buffers returned instructions with their PCs in a small FIFO for the decode stage. It handles jump redirects and cache flushes by squashing in-flight and buffered instructions.

## Interface
Parameters:
- `FIFO_DEPTH`, 2: instruction buffer entries; power of two, ≥2.
- `RESET_PC`, 16'h0000: fetch address after reset.

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `mem_req`  out  1  request outstanding; held high from submit until ack.
- `mem_addr`  out  `RW` (16)  always equals `fetch_pc`.
- `mem_ppl_submit`  out  1  one-cycle pulse that submits `mem_addr` to the cache.
- `mem_cache_flush`  out  1  cache invalidate; combinational copy of `i_flush`.
- `mem_ack`  in  1  instruction for the outstanding request is valid this cycle.
- `mem_data`  in  `I_SIZE` (32)  instruction word, valid with `mem_ack`.
- `o_valid`  out  1  FIFO head valid.
- `o_instr`  out  32  FIFO head instruction.
- `o_pc`  out  16  FIFO head PC.
- `i_ready`  in  1  decode consumes the head when `o_valid & i_ready`.
- `i_jmp`  in  1  redirect pulse.
- `i_jmp_addr`  in  16  redirect target; also sampled with `i_flush`.
- `i_flush`  in  1  cache flush plus redirect to `i_jmp_addr`.

## Operation
- Addresses are instruction-granular: each 16-bit address is one 32-bit instruction. The PC advances by 1 and wraps from 0xFFFF to 0x0000 (16-bit truncation).
- `redirect = i_jmp | i_flush`.
- `room`: (FIFO count after this cycle's push and pop) < `FIFO_DEPTH`.
- FSM states:
  - IDLE: no request in flight.
    - If `redirect`: `fetch_pc <= i_jmp_addr`, no submit, stay IDLE.
    - Else if `room`: pulse `mem_ppl_submit`, go to WAIT.
  - WAIT: one request at `fetch_pc` in flight; `mem_req`=1.
    - On `mem_ack & ~redirect`: push {`fetch_pc`, `mem_data`} and increment `fetch_pc`. Then, if `room` (push counted), pulse `mem_ppl_submit` again with the incremented PC (`mem_addr` shows the new PC combinationally) and stay in WAIT. Otherwise go to IDLE.
    - On `mem_ack & redirect`: drop the data, load `fetch_pc <= i_jmp_addr`, go to IDLE.
    - On `~mem_ack & redirect`: load `fetch_pc <= i_jmp_addr`, go to DISCARD.
  - DISCARD: a squashed request is still in flight; `mem_req`=1.
    - On `mem_ack`: drop the data, go to IDLE. If `redirect` occurs in the same cycle, it still loads the PC.
    - `redirect` without `mem_ack`: load the PC, stay in DISCARD.
- `mem_ppl_submit` is never asserted in DISCARD or in a `redirect` cycle.
- FIFO:
  - A `redirect` empties it; an arriving push and a head pop in that cycle are both ignored.
  - Otherwise push and pop may occur in the same cycle, including when the FIFO is full and `room` is computed with the pop counted.
  - Outputs come straight from the head register and are not registered again.
- The FIFO is never overrun: a request is submitted only when `room` is true, and one request at most is in flight.

## Timing
- Reset values: `mem_req`=0, `mem_ppl_submit`=0, `o_valid`=0, FSM=IDLE, `fetch_pc`=`RESET_PC`, FIFO empty. `o_instr`/`o_pc` are don't-care while `o_valid`=0. `mem_cache_flush` follows `i_flush` even during reset.
- First submit occurs in the first cycle with `i_rst`=0.
- Cache hit: `mem_ack` arrives one cycle after submit, so streaming throughput is 1 instruction/cycle.
- Misses: this block waits indefinitely in WAIT/DISCARD.
- An instruction is visible on `o_valid` the cycle after its `mem_ack`.
- After a redirect: submit of the target happens no earlier than the next cycle; the first target instruction appears no earlier than 3 cycles after the `redirect` cycle on a hit path.
- Reset asserted mid-operation overrides everything, including a same-cycle `mem_ack`. The cache is reset by the same `i_rst`, so no squash state survives.

## Test plan
- Reset with `RESET_PC`=0x0010, cache always hits with 1-cycle ack, `i_ready`=1 -> submits at 0x10, 0x11, 0x12 on consecutive cycles; `o_pc` 0x10, 0x11, 0x12 one cycle after each ack; `o_instr` matches `mem_data`.
- `i_ready`=0 with `FIFO_DEPTH`=2 -> exactly 2 entries buffered, `mem_ppl_submit` stays 0 and `mem_req`=0. Raising `i_ready` pops 0x10 and resubmits in the same cycle.
- 5-cycle miss on 0x20, `i_jmp`=1 with `i_jmp_addr`=0x80 at cycle 2 of the wait -> DISCARD; the ack data is dropped; the next submit is 0x80; the FIFO is emptied; `o_pc` never shows 0x20.
- `i_jmp` to 0x40 in the same cycle as `mem_ack` for 0x30 -> 0x30 is not pushed, no submit that cycle, 0x40 is submitted next cycle.
- `i_flush` with `i_jmp_addr`=0x05 while 2 entries are buffered -> `mem_cache_flush`=1 that cycle, FIFO empty next cycle, refetch starts at 0x05.
- Stream starting from `RESET_PC`=0xFFFE -> PCs 0xFFFE, 0xFFFF, 0x0000, 0x0001 in order.

Source files
------------

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch front end with PC tracking, redirect squash and decode FIFO
// One request in flight at most; a redirect empties the FIFO and squashes any outstanding fetch.
module ifetch_queue #(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [15:0] RESET_PC   = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic        mem_ppl_submit,
  output logic        mem_cache_flush,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [15:0] o_pc,
  input  logic        i_ready,
  input  logic        i_jmp,
  input  logic [15:0] i_jmp_addr,
  input  logic        i_flush
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t        state;
  logic [15:0]   fetch_pc;
  logic [31:0]   instr_mem [FIFO_DEPTH];
  logic [15:0]   pc_mem    [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;

  logic redirect;
  logic push;
  logic pop;
  logic room;
  logic submit;

  // Room is judged on the occupancy left after this cycle's push and pop.
  always_comb begin
    redirect    = i_jmp | i_flush;
    push        = (state == WAIT) & mem_ack & ~redirect;
    pop         = o_valid & i_ready & ~redirect;
    count_after = count + CW'(push) - CW'(pop);
    room        = count_after < CW'(FIFO_DEPTH);
    submit      = ~i_rst & ~redirect & room & ((state == IDLE) | push);
  end

  assign mem_ppl_submit  = submit;
  assign mem_req         = ~i_rst & ((state != IDLE) | submit);
  assign mem_addr        = push ? (fetch_pc + 16'd1) : fetch_pc;
  assign mem_cache_flush = i_flush;

  assign o_valid = (count != '0);
  assign o_instr = instr_mem[rd_ptr];
  assign o_pc    = pc_mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (redirect) begin
        fetch_pc <= i_jmp_addr;
      end else if (push) begin
        fetch_pc <= fetch_pc + 16'd1;
      end

      case (state)
        IDLE: begin
          if (submit) state <= WAIT;
        end
        WAIT: begin
          if (mem_ack) begin
            state <= submit ? WAIT : IDLE;
          end else if (redirect) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (mem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count_after;
      end
    end
  end

  // Storage carries no reset; entries are only read while counted valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst && push) begin
      instr_mem[wr_ptr] <= mem_data;
      pc_mem[wr_ptr]    <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - randomized bench for ifetch_queue with a queue-based reference model
module tb_ifetch_queue;

  localparam int          DEPTH = 2;
  localparam logic [15:0] RPC   = 16'h0010;

  logic        i_clk;
  logic        i_rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ppl_submit;
  logic        mem_cache_flush;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [15:0] o_pc;
  logic        i_ready;
  logic        i_jmp;
  logic [15:0] i_jmp_addr;
  logic        i_flush;

  ifetch_queue #(.FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ppl_submit(mem_ppl_submit),
    .mem_cache_flush(mem_cache_flush), .mem_ack(mem_ack), .mem_data(mem_data),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .i_ready(i_ready),
    .i_jmp(i_jmp), .i_jmp_addr(i_jmp_addr), .i_flush(i_flush)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference model: buffered entries, next fetch PC, and request status
  // (0 = nothing outstanding, 1 = live request, 2 = squashed request).
  ent_t        mq[$];
  logic [15:0] m_pc;
  int          m_infl;

  // Cache model: one outstanding request answered after a chosen latency.
  logic        c_busy;
  int          c_ack_cyc;
  logic [31:0] c_data;
  int          lat;
  int          cyc;

  logic [15:0] sub_log[$];
  logic [15:0] pop_log[$];
  logic        last_sub, last_req, last_valid, last_flush;
  logic [15:0] last_addr, last_pc;

  int n_vec;
  int n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] qget(input logic [15:0] q[$], input int i);
    if (i < q.size()) return {16'h0, q[i]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic step(input logic r, input logic rd, input logic j, input logic f,
                      input logic [15:0] ja);
    logic        redir, e_push, e_pop, e_sub, e_req;
    logic [15:0] e_addr;
    int          sz_after;
    i_rst      = r;
    i_ready    = rd;
    i_jmp      = j;
    i_flush    = f;
    i_jmp_addr = ja;
    mem_ack    = !r && c_busy && (cyc == c_ack_cyc);
    mem_data   = mem_ack ? c_data : $urandom;
    #2;
    redir    = j | f;
    e_push   = !r && (m_infl == 1) && mem_ack && !redir;
    e_pop    = !r && (mq.size() > 0) && rd && !redir;
    sz_after = redir ? 0 : int'(mq.size()) + int'(e_push) - int'(e_pop);
    e_sub    = !r && !redir && (sz_after < DEPTH) && ((m_infl == 0) || e_push);
    e_req    = !r && ((m_infl != 0) || e_sub);
    e_addr   = e_push ? m_pc + 16'd1 : m_pc;

    chk("mem_cache_flush", {31'h0, mem_cache_flush}, {31'h0, f});
    chk("mem_ppl_submit", {31'h0, mem_ppl_submit}, {31'h0, e_sub});
    chk("mem_req", {31'h0, mem_req}, {31'h0, e_req});
    if (e_sub) chk("mem_addr", {16'h0, mem_addr}, {16'h0, e_addr});
    if (cyc > 0) begin
      chk("o_valid", {31'h0, o_valid}, {31'h0, mq.size() > 0});
      if (mq.size() > 0) begin
        chk("o_pc", {16'h0, o_pc}, {16'h0, mq[0].pc});
        chk("o_instr", o_instr, mq[0].instr);
      end
    end

    if (mem_ppl_submit) sub_log.push_back(mem_addr);
    if (!r && o_valid && rd && !redir) pop_log.push_back(o_pc);
    last_sub   = mem_ppl_submit;
    last_req   = mem_req;
    last_valid = o_valid;
    last_flush = mem_cache_flush;
    last_addr  = mem_addr;
    last_pc    = o_pc;

    if (r) begin
      c_busy = 1'b0;
    end else begin
      if (mem_ack) c_busy = 1'b0;
      if (mem_ppl_submit) begin
        c_busy    = 1'b1;
        c_ack_cyc = cyc + lat;
        c_data    = $urandom;
      end
    end

    if (r) begin
      m_pc   = RPC;
      m_infl = 0;
      mq.delete();
    end else if (redir) begin
      m_pc   = ja;
      m_infl = ((m_infl != 0) && !mem_ack) ? 2 : 0;
      mq.delete();
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (e_push) begin
        mq.push_back({m_pc, mem_data});
        m_pc = m_pc + 16'd1;
      end
      if (mem_ack) m_infl = 0;
      if (e_sub) m_infl = 1;
    end

    cyc++;
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_logs();
    sub_log.delete();
    pop_log.delete();
  endtask

  initial begin
    i_clk = 0; i_rst = 1; i_ready = 0; i_jmp = 0; i_flush = 0; i_jmp_addr = 0;
    mem_ack = 0; mem_data = 0;
    n_vec = 0; n_err = 0; cyc = 0; lat = 1;
    c_busy = 0; c_ack_cyc = 0; c_data = 0;
    m_pc = RPC; m_infl = 0;
    @(posedge i_clk);
    #1;

    repeat (3) step(1, 1, 0, 0, 16'h0);
    chk("rst_req", {31'h0, last_req}, 32'h0);
    chk("rst_submit", {31'h0, last_sub}, 32'h0);

    // Streaming hits from reset.
    clear_logs();
    repeat (4) step(0, 1, 0, 0, 16'h0);
    chk("stream_sub0", qget(sub_log, 0), 32'h0010);
    chk("stream_sub1", qget(sub_log, 1), 32'h0011);
    chk("stream_sub2", qget(sub_log, 2), 32'h0012);
    chk("stream_pop0", qget(pop_log, 0), 32'h0010);
    chk("stream_pop1", qget(pop_log, 1), 32'h0011);

    // Decode stalls: FIFO fills, fetch stops, then resumes with a same-cycle pop.
    repeat (4) step(0, 0, 0, 0, 16'h0);
    chk("stall_submit", {31'h0, last_sub}, 32'h0);
    chk("stall_req", {31'h0, last_req}, 32'h0);
    chk("stall_valid", {31'h0, last_valid}, 32'h1);
    step(0, 1, 0, 0, 16'h0);
    chk("resume_pc", {16'h0, last_pc}, 32'h0012);
    chk("resume_submit", {31'h0, last_sub}, 32'h1);
    chk("resume_addr", {16'h0, last_addr}, 32'h0014);

    // Miss on 0x20 squashed by a jump to 0x80 during the wait.
    step(0, 1, 1, 0, 16'h0020);
    clear_logs();
    lat = 5;
    step(0, 1, 0, 0, 16'h0);
    lat = 1;
    step(0, 1, 0, 0, 16'h0);
    step(0, 1, 1, 0, 16'h0080);
    repeat (6) step(0, 1, 0, 0, 16'h0);
    chk("discard_sub0", qget(sub_log, 0), 32'h0020);
    chk("discard_sub1", qget(sub_log, 1), 32'h0080);
    chk("discard_pop0", qget(pop_log, 0), 32'h0080);

    // Jump to 0x40 in the same cycle as the ack for 0x30.
    step(0, 1, 1, 0, 16'h0030);
    step(0, 1, 0, 0, 16'h0);
    clear_logs();
    step(0, 1, 1, 0, 16'h0040);
    chk("jmp_ack_submit", {31'h0, last_sub}, 32'h0);
    repeat (4) step(0, 1, 0, 0, 16'h0);
    chk("jmp_ack_sub0", qget(sub_log, 0), 32'h0040);
    chk("jmp_ack_pop0", qget(pop_log, 0), 32'h0040);

    // Flush with a full FIFO.
    repeat (4) step(0, 0, 0, 0, 16'h0);
    chk("flush_prefull", {31'h0, last_valid}, 32'h1);
    step(0, 0, 0, 1, 16'h0005);
    chk("flush_out", {31'h0, last_flush}, 32'h1);
    step(0, 1, 0, 0, 16'h0);
    chk("flush_empty", {31'h0, last_valid}, 32'h0);
    chk("flush_refetch", {16'h0, last_addr}, 32'h0005);

    // PC wrap.
    step(0, 1, 1, 0, 16'hFFFE);
    clear_logs();
    repeat (8) step(0, 1, 0, 0, 16'h0);
    chk("wrap_pop0", qget(pop_log, 0), 32'hFFFE);
    chk("wrap_pop1", qget(pop_log, 1), 32'hFFFF);
    chk("wrap_pop2", qget(pop_log, 2), 32'h0000);
    chk("wrap_pop3", qget(pop_log, 3), 32'h0001);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      logic        r, rd, j, f;
      logic [15:0] ja;
      lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 6)) : 1;
      r   = ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 9) < 7);
      j   = ($urandom_range(0, 19) == 0);
      f   = ($urandom_range(0, 39) == 0);
      ja  = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                         : 16'($urandom);
      step(r, rd, j, f, ja);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
